paralelo_serial_tx: RTL and testbench

//  Transmit-side parallel-to-serial link driver: the counterpart of the serial-paralelo idle detector.

---
 rtl/paralelo_serial_tx.sv | 104 ++++++++++
 tb/tb_paralelo_serial_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial link driver: COM sync burst, one IDL, then user bytes
// or IDL filler, shifted out MSB first at one bit per clock.
module paralelo_serial_tx #(
  parameter int         N_COM   = 4,
  parameter logic [7:0] COM_SYM = 8'hBC,
  parameter logic [7:0] IDL_SYM = 8'h7C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       resync,
  output logic       serial_out,
  output logic       byte_start,
  output logic       sync_done
);

  localparam int CW = $clog2(N_COM + 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOCK = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   com_cnt, com_d;
  logic [7:0]      shift_reg, shift_d;
  logic [2:0]      bit_cnt, bit_d;
  logic            resync_pend, pend_d;

  logic            load;
  logic            do_rs;
  state_t          eff_state;
  logic [CW-1:0]   eff_com;

  assign load       = (bit_cnt == 3'd7);
  assign do_rs      = resync | resync_pend;
  assign serial_out = shift_reg[7];
  assign byte_start = (bit_cnt == 3'd0);
  assign sync_done  = (state == RUN);
  assign ready_out  = (state == RUN) & load
                    & ~resync & ~resync_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SYNC;
      com_cnt     <= '0;
      shift_reg   <= '0;
      bit_cnt     <= 3'd7;
      resync_pend <= 1'b0;
    end else begin
      state       <= state_d;
      com_cnt     <= com_d;
      shift_reg   <= shift_d;
      bit_cnt     <= bit_d;
      resync_pend <= pend_d;
    end
  end

  // A pending resync turns this load into the first COM of a fresh burst.
  always_comb begin
    state_d   = state;
    com_d     = com_cnt;
    shift_d   = {shift_reg[6:0], 1'b0};
    bit_d     = bit_cnt + 3'd1;
    pend_d    = resync_pend | resync;
    eff_state = do_rs ? SYNC : state;
    eff_com   = do_rs ? '0 : com_cnt;
    if (load) begin
      bit_d  = 3'd0;
      pend_d = 1'b0;
      unique case (eff_state)
        SYNC: begin
          shift_d = COM_SYM;
          if (eff_com == CW'(N_COM - 1)) begin
            state_d = LOCK;
            com_d   = '0;
          end else begin
            state_d = SYNC;
            com_d   = eff_com + CW'(1);
          end
        end
        LOCK: begin
          shift_d = IDL_SYM;
          state_d = RUN;
          com_d   = eff_com;
        end
        RUN: begin
          shift_d = (valid_in & ready_out) ? data_in : IDL_SYM;
          state_d = RUN;
          com_d   = eff_com;
        end
        default: begin
          shift_d = COM_SYM;
          state_d = SYNC;
          com_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: symbol-queue model, per-cycle compare,
// directed sync/data/resync/reset scenarios plus random traffic.
module tb_paralelo_serial_tx;

  localparam int         N_COM = 4;
  localparam logic [7:0] COM   = 8'hBC;
  localparam logic [7:0] IDL   = 8'h7C;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       resync = 1'b0;
  logic       serial_out;
  logic       byte_start;
  logic       sync_done;

  int n_pass = 0;
  int n_total = 0;

  paralelo_serial_tx #(
    .N_COM(N_COM), .COM_SYM(COM), .IDL_SYM(IDL)
  ) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .resync(resync),
    .serial_out(serial_out), .byte_start(byte_start),
    .sync_done(sync_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, exp, $time);
  endtask

  // Model: position within the current byte, the byte itself, and how
  // many sync-burst symbols are still owed (0 means running).
  int         m_pos = 7;
  logic [7:0] m_byte = '0;
  int         m_burst = N_COM + 1;
  bit         m_pend = 0;
  bit         m_isdata = 0;

  function automatic bit m_ready();
    return (m_burst == 0) && (m_pos == 7) && !resync && !m_pend;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pos = 7; m_byte = '0; m_burst = N_COM + 1;
      m_pend = 0; m_isdata = 0;
    end else if (m_pos == 7) begin
      bit acc;
      acc = m_ready();
      m_pos = 0;
      m_isdata = 0;
      if (resync || m_pend) begin
        m_burst = N_COM + 1;
        m_pend = 0;
      end
      if (m_burst > 1) begin
        m_byte = COM; m_burst--;
      end else if (m_burst == 1) begin
        m_byte = IDL; m_burst = 0;
      end else if (valid_in && acc) begin
        m_byte = data_in; m_isdata = 1;
      end else begin
        m_byte = IDL;
      end
    end else begin
      m_pos++;
      m_pend = m_pend | resync;
    end
  end

  always @(negedge clk) begin
    chk("serial_out", {7'd0, serial_out}, {7'd0, m_byte[7-m_pos]});
    chk("byte_start", {7'd0, byte_start}, {7'd0, m_pos == 0});
    chk("sync_done", {7'd0, sync_done}, {7'd0, m_burst == 0});
    chk("ready_out", {7'd0, ready_out}, {7'd0, m_ready()});
  end

  // Loopback deserializer plus a simple COM-run/IDL idle detector.
  logic [7:0] ds_sh;
  int         ds_cnt;
  bit         ds_act;
  int         com_run;
  bit         idle_out;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      ds_sh = '0; ds_cnt = 0; ds_act = 0;
      com_run = 0; idle_out = 0;
    end else begin
      if (byte_start) begin
        ds_cnt = 0; ds_act = 1;
      end
      if (ds_act) begin
        ds_sh = {ds_sh[6:0], serial_out};
        ds_cnt++;
        if (ds_cnt == 8) begin
          ds_act = 0;
          if (ds_sh == COM) com_run++;
          else begin
            if (ds_sh == IDL && com_run >= N_COM) idle_out = 1;
            com_run = 0;
          end
        end
      end
    end
  end

  task automatic sync_seq();
    logic [39:0] exp_bits;
    exp_bits = {COM, COM, COM, COM, IDL};
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      chk("t1_ser", {7'd0, serial_out}, {7'd0, exp_bits[40-i]});
      chk("t1_bs", {7'd0, byte_start}, {7'd0, (i % 8) == 1});
      chk("t1_sd", {7'd0, sync_done}, {7'd0, i >= 33});
      if (i == 32) chk("t6_idle_early", {7'd0, idle_out}, 8'd0);
    end
  endtask

  initial begin
    logic [7:0] a5;
    bit found;
    a5 = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ser", {7'd0, serial_out}, 8'd0);
    chk("rst_rdy", {7'd0, ready_out}, 8'd0);
    chk("rst_sd", {7'd0, sync_done}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    sync_seq();
    chk("t2_rdy", {7'd0, ready_out}, 8'd1);
    valid_in = 1'b1;
    data_in = a5;
    for (int i = 41; i <= 56; i++) begin
      @(posedge clk); #1;
      chk("t2_ser", {7'd0, serial_out}, {7'd0, a5[7-((i-41)%8)]});
    end
    chk("t6_idle", {7'd0, idle_out}, 8'd1);
    valid_in = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    // resync at bit 3 of a data byte
    valid_in = 1'b1;
    data_in = 8'h3C;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if (m_burst == 0 && m_pos == 3 && m_isdata) found = 1;
    end
    chk("t4_wait", {7'd0, found}, 8'd1);
    resync = 1'b1;
    @(posedge clk); #1;
    resync = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("t4_rdy_low", {7'd0, ready_out}, 8'd0);
    chk("t4_sd_pre", {7'd0, sync_done}, 8'd1);
    @(posedge clk); #1;
    chk("t4_sd", {7'd0, sync_done}, 8'd0);
    chk("t4_com", {7'd0, serial_out}, 8'd1);
    for (int k = 0; k < 3000; k++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      data_in = 8'($urandom);
      resync = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end
    resync = 1'b1;
    @(posedge clk); #1;
    resync = 1'b0;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(posedge clk); #1;
      if (m_burst > 1 && m_pos == 4) found = 1;
    end
    chk("t5_wait", {7'd0, found}, 8'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_ser", {7'd0, serial_out}, 8'd0);
    chk("t5_bs", {7'd0, byte_start}, 8'd0);
    chk("t5_sd", {7'd0, sync_done}, 8'd0);
    chk("t5_rdy", {7'd0, ready_out}, 8'd0);
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sync_seq();
    @(posedge clk); #1;
    chk("t6_idle2", {7'd0, idle_out}, 8'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
